// File: rtl/axi_lite_router.sv
// AXI-Lite 1-to-2 address router: independent single-outstanding read and write paths.
// Every s-side output is driven from a register, so no m-side input reaches it combinationally.
module axi_lite_router #(
  parameter logic [31:0] M0_BASE = 32'h0000_0000,
  parameter logic [31:0] M0_MASK = 32'hF000_0000,
  parameter logic [31:0] M1_BASE = 32'h1000_0000,
  parameter logic [31:0] M1_MASK = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  // upstream
  input  logic [31:0] s_araddr,
  input  logic [2:0]  s_arprot,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  input  logic [31:0] s_awaddr,
  input  logic [2:0]  s_awprot,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  // downstream port 0
  output logic [31:0] m0_araddr,
  output logic [2:0]  m0_arprot,
  output logic        m0_arvalid,
  input  logic        m0_arready,
  input  logic [31:0] m0_rdata,
  input  logic [1:0]  m0_rresp,
  input  logic        m0_rvalid,
  output logic        m0_rready,
  output logic [31:0] m0_awaddr,
  output logic [2:0]  m0_awprot,
  output logic        m0_awvalid,
  input  logic        m0_awready,
  output logic [31:0] m0_wdata,
  output logic [3:0]  m0_wstrb,
  output logic        m0_wvalid,
  input  logic        m0_wready,
  input  logic [1:0]  m0_bresp,
  input  logic        m0_bvalid,
  output logic        m0_bready,
  // downstream port 1
  output logic [31:0] m1_araddr,
  output logic [2:0]  m1_arprot,
  output logic        m1_arvalid,
  input  logic        m1_arready,
  input  logic [31:0] m1_rdata,
  input  logic [1:0]  m1_rresp,
  input  logic        m1_rvalid,
  output logic        m1_rready,
  output logic [31:0] m1_awaddr,
  output logic [2:0]  m1_awprot,
  output logic        m1_awvalid,
  input  logic        m1_awready,
  output logic [31:0] m1_wdata,
  output logic [3:0]  m1_wstrb,
  output logic        m1_wvalid,
  input  logic        m1_wready,
  input  logic [1:0]  m1_bresp,
  input  logic        m1_bvalid,
  output logic        m1_bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_BWAIT, W_RESP} w_state_e;

  localparam logic [1:0] RespDecErr = 2'b11;

  // Returns {mapped, port}; port 0 has priority when both windows match.
  function automatic logic [1:0] decode(input logic [31:0] addr);
    if ((addr & M0_MASK) == M0_BASE) begin
      return 2'b10;
    end else if ((addr & M1_MASK) == M1_BASE) begin
      return 2'b11;
    end
    return 2'b00;
  endfunction

  logic [1:0] r_dec, aw_dec;
  assign r_dec  = decode(s_araddr);
  assign aw_dec = decode(s_awaddr);

  // ---------------- read path ----------------
  r_state_e    r_state_q, r_state_d;
  logic        r_port_q, r_port_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic [2:0]  r_prot_q, r_prot_d;
  logic [31:0] r_data_q, r_data_d;
  logic [1:0]  r_resp_q, r_resp_d;

  logic        r_sel_arready, r_sel_rvalid;
  logic [31:0] r_sel_rdata;
  logic [1:0]  r_sel_rresp;

  assign r_sel_arready = r_port_q ? m1_arready : m0_arready;
  assign r_sel_rvalid  = r_port_q ? m1_rvalid  : m0_rvalid;
  assign r_sel_rdata   = r_port_q ? m1_rdata   : m0_rdata;
  assign r_sel_rresp   = r_port_q ? m1_rresp   : m0_rresp;

  always_comb begin
    r_state_d = r_state_q;
    r_port_d  = r_port_q;
    r_addr_d  = r_addr_q;
    r_prot_d  = r_prot_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (s_arvalid) begin
          r_addr_d = s_araddr;
          r_prot_d = s_arprot;
          r_port_d = r_dec[0];
          if (r_dec[1]) begin
            r_state_d = R_ADDR;
          end else begin
            r_data_d  = '0;
            r_resp_d  = RespDecErr;
            r_state_d = R_RESP;
          end
        end
      end
      R_ADDR: if (r_sel_arready) r_state_d = R_DATA;
      R_DATA: begin
        if (r_sel_rvalid) begin
          r_data_d  = r_sel_rdata;
          r_resp_d  = r_sel_rresp;
          r_state_d = R_RESP;
        end
      end
      R_RESP: if (s_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      r_port_q  <= 1'b0;
      r_addr_q  <= '0;
      r_prot_q  <= '0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_port_q  <= r_port_d;
      r_addr_q  <= r_addr_d;
      r_prot_q  <= r_prot_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  assign s_arready  = (r_state_q == R_IDLE);
  assign s_rvalid   = (r_state_q == R_RESP);
  assign s_rdata    = r_data_q;
  assign s_rresp    = r_resp_q;
  assign m0_araddr  = r_addr_q;
  assign m1_araddr  = r_addr_q;
  assign m0_arprot  = r_prot_q;
  assign m1_arprot  = r_prot_q;
  assign m0_arvalid = (r_state_q == R_ADDR) && !r_port_q;
  assign m1_arvalid = (r_state_q == R_ADDR) &&  r_port_q;
  assign m0_rready  = (r_state_q == R_DATA) && !r_port_q;
  assign m1_rready  = (r_state_q == R_DATA) &&  r_port_q;

  // ---------------- write path ----------------
  // aw_flag/w_flag mean "beat captured" in W_IDLE and "beat forwarded" in W_FWD.
  w_state_e    w_state_q, w_state_d;
  logic        w_port_q, w_port_d;
  logic        w_mapped_q, w_mapped_d;
  logic        aw_flag_q, aw_flag_d;
  logic        w_flag_q, w_flag_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [2:0]  w_prot_q, w_prot_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic [1:0]  b_resp_q, b_resp_d;

  logic       w_sel_awready, w_sel_wready, w_sel_bvalid;
  logic [1:0] w_sel_bresp;
  logic       aw_hs, w_hs, aw_done, w_done, mapped_now;

  assign w_sel_awready = w_port_q ? m1_awready : m0_awready;
  assign w_sel_wready  = w_port_q ? m1_wready  : m0_wready;
  assign w_sel_bvalid  = w_port_q ? m1_bvalid  : m0_bvalid;
  assign w_sel_bresp   = w_port_q ? m1_bresp   : m0_bresp;

  always_comb begin
    w_state_d  = w_state_q;
    w_port_d   = w_port_q;
    w_mapped_d = w_mapped_q;
    aw_flag_d  = aw_flag_q;
    w_flag_d   = w_flag_q;
    w_addr_d   = w_addr_q;
    w_prot_d   = w_prot_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    b_resp_d   = b_resp_q;
    aw_hs      = s_awvalid && !aw_flag_q;
    w_hs       = s_wvalid && !w_flag_q;
    aw_done    = aw_flag_q || w_sel_awready;
    w_done     = w_flag_q || w_sel_wready;
    mapped_now = aw_hs ? aw_dec[1] : w_mapped_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          w_addr_d   = s_awaddr;
          w_prot_d   = s_awprot;
          w_port_d   = aw_dec[0];
          w_mapped_d = aw_dec[1];
          aw_flag_d  = 1'b1;
        end
        if (w_hs) begin
          w_data_d = s_wdata;
          w_strb_d = s_wstrb;
          w_flag_d = 1'b1;
        end
        if ((aw_flag_q || aw_hs) && (w_flag_q || w_hs)) begin
          aw_flag_d = 1'b0;
          w_flag_d  = 1'b0;
          if (mapped_now) begin
            w_state_d = W_FWD;
          end else begin
            b_resp_d  = RespDecErr;
            w_state_d = W_RESP;
          end
        end
      end
      W_FWD: begin
        aw_flag_d = aw_done;
        w_flag_d  = w_done;
        if (aw_done && w_done) begin
          aw_flag_d = 1'b0;
          w_flag_d  = 1'b0;
          w_state_d = W_BWAIT;
        end
      end
      W_BWAIT: begin
        if (w_sel_bvalid) begin
          b_resp_d  = w_sel_bresp;
          w_state_d = W_RESP;
        end
      end
      W_RESP: if (s_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state_q  <= W_IDLE;
      w_port_q   <= 1'b0;
      w_mapped_q <= 1'b0;
      aw_flag_q  <= 1'b0;
      w_flag_q   <= 1'b0;
      w_addr_q   <= '0;
      w_prot_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_resp_q   <= '0;
    end else begin
      w_state_q  <= w_state_d;
      w_port_q   <= w_port_d;
      w_mapped_q <= w_mapped_d;
      aw_flag_q  <= aw_flag_d;
      w_flag_q   <= w_flag_d;
      w_addr_q   <= w_addr_d;
      w_prot_q   <= w_prot_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      b_resp_q   <= b_resp_d;
    end
  end

  assign s_awready  = (w_state_q == W_IDLE) && !aw_flag_q;
  assign s_wready   = (w_state_q == W_IDLE) && !w_flag_q;
  assign s_bvalid   = (w_state_q == W_RESP);
  assign s_bresp    = b_resp_q;
  assign m0_awaddr  = w_addr_q;
  assign m1_awaddr  = w_addr_q;
  assign m0_awprot  = w_prot_q;
  assign m1_awprot  = w_prot_q;
  assign m0_wdata   = w_data_q;
  assign m1_wdata   = w_data_q;
  assign m0_wstrb   = w_strb_q;
  assign m1_wstrb   = w_strb_q;
  assign m0_awvalid = (w_state_q == W_FWD) && !w_port_q && !aw_flag_q;
  assign m1_awvalid = (w_state_q == W_FWD) &&  w_port_q && !aw_flag_q;
  assign m0_wvalid  = (w_state_q == W_FWD) && !w_port_q && !w_flag_q;
  assign m1_wvalid  = (w_state_q == W_FWD) &&  w_port_q && !w_flag_q;
  assign m0_bready  = (w_state_q == W_BWAIT) && !w_port_q;
  assign m1_bready  = (w_state_q == W_BWAIT) &&  w_port_q;

endmodule
